// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: packet-level round-robin arbiter sharing one 10G MAC
// Avalon-ST TX sink between two sources, with idle gap and stall abort.
module eth_tx_arbiter #(
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_W      = 16
) (
  input  logic             clk_156_25,
  input  logic             rst,
  input  logic             ch0_valid,
  input  logic             ch0_sop,
  input  logic             ch0_eop,
  input  logic [63:0]      ch0_data,
  input  logic [2:0]       ch0_empty,
  input  logic             ch0_error,
  output logic             ch0_ready,
  input  logic             ch1_valid,
  input  logic             ch1_sop,
  input  logic             ch1_eop,
  input  logic [63:0]      ch1_data,
  input  logic [2:0]       ch1_empty,
  input  logic             ch1_error,
  output logic             ch1_ready,
  output logic             avalon_st_tx_valid,
  output logic             avalon_st_tx_startofpacket,
  output logic             avalon_st_tx_endofpacket,
  output logic [63:0]      avalon_st_tx_data,
  output logic [2:0]       avalon_st_tx_empty,
  output logic             avalon_st_tx_error,
  input  logic             avalon_st_tx_ready,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1,
  output logic [CNT_W-1:0] abort_cnt,
  output logic             proto_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_ABORT,
    S_GAP
  } state_t;

  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_INIT =
    (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
  localparam state_t PKT_DONE = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;

  state_t           state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [TW-1:0]    to_cnt_q, to_cnt_d;
  logic             flush0_q, flush0_d;
  logic             flush1_q, flush1_d;
  logic [CNT_W-1:0] pkt_cnt0_q, pkt_cnt0_d;
  logic [CNT_W-1:0] pkt_cnt1_q, pkt_cnt1_d;
  logic [CNT_W-1:0] abort_cnt_q, abort_cnt_d;
  logic             proto_err_q, proto_err_d;

  logic        in_xfer, req0, req1, disc0, disc1, stray0, stray1, pick;
  logic        cur_valid, cur_sop, cur_eop, cur_error;
  logic [63:0] cur_data;
  logic [2:0]  cur_empty;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    gap_cnt_d    = gap_cnt_q;
    to_cnt_d     = to_cnt_q;
    flush0_d     = flush0_q;
    flush1_d     = flush1_q;
    pkt_cnt0_d   = pkt_cnt0_q;
    pkt_cnt1_d   = pkt_cnt1_q;
    abort_cnt_d  = abort_cnt_q;
    proto_err_d  = 1'b0;
    pick         = 1'b0;

    in_xfer = (state_q == S_XFER);
    req0    = ch0_valid & ch0_sop & ~flush0_q;
    req1    = ch1_valid & ch1_sop & ~flush1_q;
    disc0   = flush0_q & ~(in_xfer & ~grant_q);
    disc1   = flush1_q & ~(in_xfer & grant_q);
    stray0  = (state_q == S_IDLE) & ~flush0_q & ch0_valid & ~ch0_sop;
    stray1  = (state_q == S_IDLE) & ~flush1_q & ch1_valid & ~ch1_sop;

    cur_valid = grant_q ? ch1_valid : ch0_valid;
    cur_sop   = grant_q ? ch1_sop   : ch0_sop;
    cur_eop   = grant_q ? ch1_eop   : ch0_eop;
    cur_data  = grant_q ? ch1_data  : ch0_data;
    cur_empty = grant_q ? ch1_empty : ch0_empty;
    cur_error = grant_q ? ch1_error : ch0_error;

    ch0_ready = disc0 | stray0;
    ch1_ready = disc1 | stray1;
    avalon_st_tx_valid         = 1'b0;
    avalon_st_tx_startofpacket = 1'b0;
    avalon_st_tx_endofpacket   = 1'b0;
    avalon_st_tx_data          = '0;
    avalon_st_tx_empty         = '0;
    avalon_st_tx_error         = 1'b0;

    // a flushed source is drained until its own eop goes by
    if (disc0 & ch0_valid & ch0_eop) flush0_d = 1'b0;
    if (disc1 & ch1_valid & ch1_eop) flush1_d = 1'b0;
    if (stray0 | stray1) proto_err_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          pick         = (req0 & req1) ? ~last_grant_q : req1;
          grant_d      = pick;
          last_grant_d = pick;
          to_cnt_d     = '0;
          state_d      = S_XFER;
        end
      end
      S_XFER: begin
        avalon_st_tx_valid         = cur_valid;
        avalon_st_tx_startofpacket = cur_sop;
        avalon_st_tx_endofpacket   = cur_eop;
        avalon_st_tx_data          = cur_data;
        avalon_st_tx_empty         = cur_empty;
        avalon_st_tx_error         = cur_error;
        if (grant_q) ch1_ready = avalon_st_tx_ready;
        else         ch0_ready = avalon_st_tx_ready;
        if (cur_valid) begin
          to_cnt_d = '0;
          if (avalon_st_tx_ready & cur_eop) begin
            if (grant_q) pkt_cnt1_d = pkt_cnt1_q + CNT_W'(1);
            else         pkt_cnt0_d = pkt_cnt0_q + CNT_W'(1);
            state_d   = PKT_DONE;
            gap_cnt_d = GAP_INIT;
          end
        end else if (to_cnt_q == TO_LAST) begin
          state_d = S_ABORT;
          if (grant_q) flush1_d = 1'b1;
          else         flush0_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      S_ABORT: begin
        avalon_st_tx_valid       = 1'b1;
        avalon_st_tx_endofpacket = 1'b1;
        avalon_st_tx_error       = 1'b1;
        if (avalon_st_tx_ready) begin
          if (abort_cnt_q != '1) abort_cnt_d = abort_cnt_q + CNT_W'(1);
          state_d   = PKT_DONE;
          gap_cnt_d = GAP_INIT;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) state_d = S_IDLE;
        else gap_cnt_d = gap_cnt_q - GW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_156_25) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      gap_cnt_q    <= '0;
      to_cnt_q     <= '0;
      flush0_q     <= 1'b0;
      flush1_q     <= 1'b0;
      pkt_cnt0_q   <= '0;
      pkt_cnt1_q   <= '0;
      abort_cnt_q  <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      gap_cnt_q    <= gap_cnt_d;
      to_cnt_q     <= to_cnt_d;
      flush0_q     <= flush0_d;
      flush1_q     <= flush1_d;
      pkt_cnt0_q   <= pkt_cnt0_d;
      pkt_cnt1_q   <= pkt_cnt1_d;
      abort_cnt_q  <= abort_cnt_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign pkt_cnt0  = pkt_cnt0_q;
  assign pkt_cnt1  = pkt_cnt1_q;
  assign abort_cnt = abort_cnt_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter: vector table, hand sequences and randomized
// traffic against a packet-queue model of the two-source TX arbiter.
module tb_eth_tx_arbiter;
  localparam int GAP = 2;
  localparam int TO  = 1024;
  localparam int CW  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          ch0_valid, ch0_sop, ch0_eop, ch0_error, ch0_ready;
  logic          ch1_valid, ch1_sop, ch1_eop, ch1_error, ch1_ready;
  logic [63:0]   ch0_data, ch1_data;
  logic [2:0]    ch0_empty, ch1_empty;
  logic          tx_valid, tx_sop, tx_eop, tx_error, tx_ready;
  logic [63:0]   tx_data;
  logic [2:0]    tx_empty;
  logic          busy, proto_err;
  logic [CW-1:0] pkt_cnt0, pkt_cnt1, abort_cnt;

  eth_tx_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_156_25(clk), .rst(rst),
    .ch0_valid(ch0_valid), .ch0_sop(ch0_sop), .ch0_eop(ch0_eop),
    .ch0_data(ch0_data), .ch0_empty(ch0_empty), .ch0_error(ch0_error),
    .ch0_ready(ch0_ready),
    .ch1_valid(ch1_valid), .ch1_sop(ch1_sop), .ch1_eop(ch1_eop),
    .ch1_data(ch1_data), .ch1_empty(ch1_empty), .ch1_error(ch1_error),
    .ch1_ready(ch1_ready),
    .avalon_st_tx_valid(tx_valid),
    .avalon_st_tx_startofpacket(tx_sop),
    .avalon_st_tx_endofpacket(tx_eop),
    .avalon_st_tx_data(tx_data),
    .avalon_st_tx_empty(tx_empty),
    .avalon_st_tx_error(tx_error),
    .avalon_st_tx_ready(tx_ready),
    .busy(busy), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1),
    .abort_cnt(abort_cnt), .proto_err(proto_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    {ch0_valid, ch0_sop, ch0_eop, ch0_error, ch0_empty, ch0_data} = '0;
    {ch1_valid, ch1_sop, ch1_eop, ch1_error, ch1_empty, ch1_data} = '0;
  endtask

  task automatic do_reset();
    idle_in();
    tx_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  function automatic logic [122:0] all_outs();
    return {tx_valid, tx_sop, tx_eop, tx_error, tx_empty, tx_data,
            ch0_ready, ch1_ready, busy, proto_err,
            pkt_cnt0, pkt_cnt1, abort_cnt};
  endfunction

  // ---------------- packet-queue reference model ----------------
  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
    logic        err;
    logic [63:0] data;
  } beat_t;

  beat_t src0[$], src1[$], exp0[$], exp1[$];
  int    order_q[$];

  task automatic gen_pkts(input int ch, input int n, input int flen);
    for (int p = 0; p < n; p++) begin
      int len;
      len = (flen > 0) ? flen : int'($urandom_range(1, 6));
      for (int b = 0; b < len; b++) begin
        beat_t bt;
        bt.sop   = (b == 0);
        bt.eop   = (b == len - 1);
        bt.empty = bt.eop ? 3'($urandom_range(0, 7)) : 3'd0;
        bt.err   = bt.eop ? ($urandom_range(0, 9) == 0) : 1'b0;
        bt.data  = {ch[0], 15'(p), 16'(b), $urandom()};
        if (ch == 0) begin src0.push_back(bt); exp0.push_back(bt); end
        else         begin src1.push_back(bt); exp1.push_back(bt); end
      end
    end
  endtask

  // rdy_mode: 0 random, 1 toggling, 2 always ready
  task automatic run_traffic(input int drop_pct, input int rdy_mode,
                             input int stall_at, input bit strict_gap,
                             input int budget);
    int    cyc, ch, cur_ch, gap_run;
    bit    in_pkt, gap_arm;
    beat_t got, want;
    cyc = 0; cur_ch = 0; gap_run = 0; in_pkt = 0; gap_arm = 0;
    order_q.delete();
    while ((src0.size() + src1.size() + exp0.size() + exp1.size()) != 0
           && cyc < budget) begin
      idle_in();
      if (src0.size() != 0) begin
        {ch0_sop, ch0_eop, ch0_empty, ch0_error, ch0_data} = src0[0];
        ch0_valid = ($urandom_range(0, 99) >= drop_pct);
      end
      if (src1.size() != 0) begin
        {ch1_sop, ch1_eop, ch1_empty, ch1_error, ch1_data} = src1[0];
        ch1_valid = ($urandom_range(0, 99) >= drop_pct);
      end
      case (rdy_mode)
        0:       tx_ready = ($urandom_range(0, 99) < 70);
        1:       tx_ready = (cyc % 2 == 1);
        default: tx_ready = 1'b1;
      endcase
      if (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 2000)
        tx_ready = 1'b0;
      @(negedge clk);
      if (ch0_valid && ch0_ready) void'(src0.pop_front());
      if (ch1_valid && ch1_ready) void'(src1.pop_front());
      if (gap_arm && tx_valid) begin
        if (strict_gap) chk("gap_exact", gap_run, GAP + 1);
        else            chk("gap_min", gap_run >= GAP + 1, 1'b1);
        gap_arm = 0;
      end else if (gap_arm) begin
        gap_run++;
      end
      if (tx_valid && tx_ready) begin
        got = {tx_sop, tx_eop, tx_empty, tx_error, tx_data};
        ch  = int'(tx_data[63]);
        if (in_pkt) chk("no_interleave", ch, cur_ch);
        if ((ch == 0 ? exp0.size() : exp1.size()) == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL extra_beat: got %0h want none", got);
        end else begin
          want = (ch == 0) ? exp0.pop_front() : exp1.pop_front();
          chk($sformatf("beat_ch%0d", ch), got, want);
        end
        if (got.sop) order_q.push_back(ch);
        in_pkt = !got.eop;
        cur_ch = ch;
        if (got.eop) begin gap_arm = 1; gap_run = 0; end
      end
      step();
      cyc++;
    end
    n_cmp++;
    if (cyc >= budget) begin
      n_bad++;
      $display("FAIL traffic_budget: got %0d cycles want < %0d",
               cyc, budget);
    end
    idle_in();
    tx_ready = 1'b1;
  endtask

  // ---------------- single-source vector table ----------------
  typedef struct packed {
    logic        v0;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
    logic [63:0] data;
    logic [4:0]  ctl;   // {tx_valid, tx_sop, tx_eop, ch0_ready, busy}
    logic [2:0]  x_empty;
    logic [63:0] x_data;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int seen;
    rst = 1'b0;
    tx_ready = 1'b1;
    idle_in();

    tbl[0] = '{1, 1, 0, 3'd0, 64'd1, 5'b00000, 3'd0, 64'd0};
    tbl[1] = '{1, 1, 0, 3'd0, 64'd1, 5'b11011, 3'd0, 64'd1};
    tbl[2] = '{1, 0, 0, 3'd0, 64'd2, 5'b10011, 3'd0, 64'd2};
    tbl[3] = '{1, 0, 0, 3'd0, 64'd3, 5'b10011, 3'd0, 64'd3};
    tbl[4] = '{1, 0, 1, 3'd3, 64'd4, 5'b10111, 3'd3, 64'd4};
    tbl[5] = '{1, 1, 1, 3'd0, 64'd5, 5'b00001, 3'd0, 64'd0};
    tbl[6] = '{1, 1, 1, 3'd0, 64'd5, 5'b00001, 3'd0, 64'd0};
    tbl[7] = '{1, 1, 1, 3'd0, 64'd5, 5'b00000, 3'd0, 64'd0};
    tbl[8] = '{1, 1, 1, 3'd0, 64'd5, 5'b11111, 3'd0, 64'd5};
    tbl[9] = '{0, 0, 0, 3'd0, 64'd0, 5'b00001, 3'd0, 64'd0};

    // reset state
    do_reset();
    @(negedge clk);
    chk("reset_state", all_outs(), '0);
    step();

    // 4-beat packet, then a single-beat packet behind the gap
    for (int i = 0; i < 10; i++) begin
      idle_in();
      ch0_valid = tbl[i].v0;
      ch0_sop   = tbl[i].sop;
      ch0_eop   = tbl[i].eop;
      ch0_empty = tbl[i].empty;
      ch0_data  = tbl[i].data;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {tx_valid, tx_sop, tx_eop, ch0_ready, busy, tx_empty, tx_data},
          {tbl[i].ctl, tbl[i].x_empty, tbl[i].x_data});
      step();
    end
    chk("pkt_cnt0_after_vec", pkt_cnt0, 2);

    // reset in XFER mid-packet
    do_reset();
    ch0_valid = 1; ch0_sop = 1; ch0_data = 64'hA1;
    step();
    step();
    ch0_sop = 0; ch0_data = 64'hA2;
    @(negedge clk);
    chk("mid_pkt_busy", {busy, tx_valid}, 2'b11);
    idle_in();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_mid_pkt", all_outs(), '0);
    step();
    ch1_valid = 1; ch1_sop = 1; ch1_eop = 1; ch1_data = 64'hB1;
    @(negedge clk);
    chk("post_rst_arb", tx_valid, 1'b0);
    step();
    @(negedge clk);
    chk("post_rst_grant", {tx_valid, tx_sop, tx_eop, ch1_ready, tx_data},
        {4'b1111, 64'hB1});
    step();
    idle_in();
    chk("post_rst_cnt1", pkt_cnt1, 1);

    // stray beat in IDLE
    do_reset();
    ch1_valid = 1; ch1_data = 64'hC1;
    @(negedge clk);
    chk("stray_ready", {ch1_ready, tx_valid, proto_err}, 3'b100);
    step();
    idle_in();
    @(negedge clk);
    chk("stray_pulse", {proto_err, busy, tx_valid}, 3'b100);
    step();
    @(negedge clk);
    chk("stray_pulse_end", proto_err, 1'b0);
    step();

    // contention from reset: strict alternation starting with ch0
    do_reset();
    gen_pkts(0, 3, 0);
    gen_pkts(1, 3, 0);
    run_traffic(0, 2, -1, 1'b1, 500);
    chk("rr_count", order_q.size(), 6);
    for (int i = 0; i < order_q.size(); i++)
      chk($sformatf("rr_order%0d", i), order_q[i], i % 2);
    chk("rr_pkt_cnts", {pkt_cnt0, pkt_cnt1}, {16'd3, 16'd3});

    // MAC backpressure, including a 2000-cycle stall mid-packet
    do_reset();
    gen_pkts(1, 1, 6);
    run_traffic(0, 1, 4, 1'b0, 3000);
    chk("bp_no_abort", {abort_cnt, pkt_cnt1}, {16'd0, 16'd1});

    // source stall -> abort, flush, then normal traffic
    do_reset();
    ch0_valid = 1; ch0_sop = 1; ch0_data = 64'hD1;
    step();
    step();
    ch0_sop = 0; ch0_data = 64'hD2;
    step();
    idle_in();
    seen = 0;
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      if (tx_valid) seen++;
      step();
    end
    chk("to_quiet", seen, 0);
    @(negedge clk);
    chk("abort_beat",
        {tx_valid, tx_sop, tx_eop, tx_error, tx_empty, tx_data, ch0_ready},
        {4'b1011, 3'd0, 64'd0, 1'b1});
    step();
    ch0_valid = 1; ch0_data = 64'hD3;
    @(negedge clk);
    chk("flush_beat3", {ch0_ready, tx_valid}, 2'b10);
    step();
    ch0_eop = 1; ch0_data = 64'hD4;
    @(negedge clk);
    chk("flush_beat4", {ch0_ready, tx_valid}, 2'b10);
    step();
    idle_in();
    @(negedge clk);
    chk("abort_cnts", {abort_cnt, pkt_cnt0, proto_err},
        {16'd1, 16'd0, 1'b0});
    step();
    gen_pkts(1, 1, 0);
    gen_pkts(0, 1, 0);
    run_traffic(0, 2, -1, 1'b0, 200);
    chk("after_abort_cnts", {pkt_cnt0, pkt_cnt1, abort_cnt},
        {16'd1, 16'd1, 16'd1});

    // randomized traffic
    do_reset();
    gen_pkts(0, 12, 0);
    gen_pkts(1, 12, 0);
    run_traffic(25, 0, -1, 1'b0, 5000);
    chk("rand_cnts", {pkt_cnt0, pkt_cnt1, abort_cnt},
        {16'd12, 16'd12, 16'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
